div_unit: RTL and testbench

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the execute stage beside the single-cycle Alu and is driven by the same control path. A start pulse launches an operation; the block asserts busy so the pipeline stalls, then pulses done with the result. All RISC-V division corner cases are handled in-block, with no trap.

---
 rtl/div_unit_pkg.sv | 20 ++
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit_step.sv | 30 +++
 rtl/div_unit.sv | 147 ++++++++++++++
 tb/tb_div_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: op encodings and op decode helpers
// shared by the RV32M iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  function automatic logic op_signed(div_op_e op);
    return !op[0];
  endfunction

  function automatic logic op_rem(div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: start/operand request and
// busy/done/result response of the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );

endinterface

// File: rtl/div_unit_step.sv
// div_unit_step: one restoring-division iteration
// (shift, compare, conditional subtract).
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;
  logic [WIDTH:0] diff;
  logic           ge;
  logic           unused_msb;

  // the partial remainder always fits in WIDTH bits
  assign unused_msb = rem_i[WIDTH];

  assign shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign dvs_ext = {1'b0, divisor_i};
  assign diff    = shifted - dvs_ext;
  assign ge      = shifted >= dvs_ext;

  assign rem_o = ge ? diff : shifted;
  assign quo_o = {quo_i[WIDTH-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider for RV32M
// DIV/DIVU/REM/REMU, one quotient bit per cycle.
import div_unit_pkg::*;

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  div_op_e          op_q, op_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             nq_q, nq_d;
  logic             nr_q, nr_d;

  div_op_e          op_in;
  logic             sgn_in;
  logic             rem_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             ovf;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] rem_lo;
  logic [WIDTH-1:0] fin_res;

  assign op_in  = div_op_e'(bus.op);
  assign sgn_in = op_signed(op_in);
  assign rem_in = op_rem(op_in);

  // |MIN_NEG| wraps to itself, which is right as unsigned
  assign a_mag = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  assign b_zero = (bus.b == '0);
  assign ovf    = sgn_in && (bus.a == MIN_NEG) && (&bus.b);

  div_unit_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  assign rem_lo  = step_rem[WIDTH-1:0];
  assign fin_res = op_rem(op_q)
                 ? (nr_q ? -rem_lo : rem_lo)
                 : (nq_q ? -step_quo : step_quo);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = op_in;
          dvs_d = b_mag;
          quo_d = a_mag;
          rem_d = '0;
          cnt_d = CW'(WIDTH);
          nq_d  = sgn_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          nr_d  = sgn_in & bus.a[WIDTH-1];
          unique case (1'b1)
            b_zero: begin
              state_d = S_DONE;
              res_d   = rem_in ? bus.a : '1;
            end
            ovf: begin
              state_d = S_DONE;
              res_d   = rem_in ? '0 : bus.a;
            end
            default: state_d = S_CALC;
          endcase
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = fin_res;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= DIV_OP_DIV;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with a
// cycle-level reference model and per-cycle compare.
import div_unit_pkg::*;

module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  div_unit_if #(.WIDTH(32)) bus ();

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(
    input logic [1:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic sg;
    logic rm;
    sg = (o == 2'b00) || (o == 2'b10);
    rm = o[1];
    if (y == 32'h0) return rm ? x : 32'hFFFF_FFFF;
    if (sg && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return rm ? 32'h0 : x;
    if (sg)
      return rm ? 32'($signed(x) % $signed(y))
                : 32'($signed(x) / $signed(y));
    return rm ? x % y : x / y;
  endfunction

  function automatic logic is_special(
    input logic [1:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic sg;
    sg = (o == 2'b00) || (o == 2'b10);
    return (y == 32'h0) ||
           (sg && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  task automatic check(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  // m_left: cycles still to run including the done cycle
  int          m_left = 0;
  logic [31:0] m_res  = 32'h0;
  logic [31:0] m_pend = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_res  <= 32'h0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        m_pend <= ref_div(bus.op, bus.a, bus.b);
        if (is_special(bus.op, bus.a, bus.b)) begin
          m_left <= 1;
          m_res  <= ref_div(bus.op, bus.a, bus.b);
        end else begin
          m_left <= 33;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_res <= m_pend;
    end
  end

  always @(posedge clk) begin
    #1;
    check("cyc busy", 32'(bus.busy), 32'(m_left != 0));
    check("cyc done", 32'(bus.done), 32'(m_left == 1));
    check("cyc result", bus.result, m_res);
  end

  task automatic launch(
    input logic [1:0]  o,
    input logic [31:0] x,
    input logic [31:0] y
  );
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.a     = ~x;
    bus.b     = y + 32'd3;
  endtask

  task automatic wait_done(input int poke, output int n);
    n = 1;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
      bus.start = (n == poke);
    end
    bus.start = 1'b0;
  endtask

  task automatic run(
    input string       nm,
    input logic [1:0]  o,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] exp,
    input int          lat,
    input int          poke
  );
    int n;
    launch(o, x, y);
    wait_done(poke, n);
    check({nm, " model"}, ref_div(o, x, y), exp);
    check({nm, " latency"}, 32'(n), 32'(lat));
    check({nm, " result"}, bus.result, exp);
  endtask

  initial begin
    int n;
    int dn;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset done", 32'(bus.done), 32'h0);
    check("reset result", bus.result, 32'h0);
    rst = 1'b0;

    run("div 100/7 poke", DIV_OP_DIV, 32'd100, 32'd7,
        32'd14, 33, 10);
    run("rem 100/7", DIV_OP_REM, 32'd100, 32'd7,
        32'd2, 33, 0);
    run("div -100/7", DIV_OP_DIV, 32'hFFFF_FF9C, 32'd7,
        32'hFFFF_FFF2, 33, 0);
    run("rem -100/7", DIV_OP_REM, 32'hFFFF_FF9C, 32'd7,
        32'hFFFF_FFFE, 33, 0);
    run("div 100/-7", DIV_OP_DIV, 32'd100, 32'hFFFF_FFF9,
        32'hFFFF_FFF2, 33, 0);
    run("rem 100/-7", DIV_OP_REM, 32'd100, 32'hFFFF_FFF9,
        32'd2, 33, 0);
    run("divu ff/2", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd2,
        32'h7FFF_FFFF, 33, 0);
    run("remu ff/2", DIV_OP_REMU, 32'hFFFF_FFFF, 32'd2,
        32'd1, 33, 0);
    run("div -1/2", DIV_OP_DIV, 32'hFFFF_FFFF, 32'd2,
        32'd0, 33, 0);
    run("div 5/0", DIV_OP_DIV, 32'd5, 32'd0,
        32'hFFFF_FFFF, 1, 0);
    run("remu 5/0", DIV_OP_REMU, 32'd5, 32'd0,
        32'd5, 1, 0);
    run("div ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1, 0);
    run("rem ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 1, 0);
    run("divu big", DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 33, 0);

    // start held through DONE: taken only in the IDLE cycle
    run("div hold", DIV_OP_DIV, 32'd100, 32'd7,
        32'd14, 33, 0);
    bus.start = 1'b1;
    bus.op    = DIV_OP_DIVU;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'd2;
    @(negedge clk);
    check("hold idle busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    bus.start = 1'b0;
    check("hold accept busy", 32'(bus.busy), 32'h1);
    wait_done(0, n);
    check("hold latency", 32'(n), 32'd33);
    check("hold result", bus.result, 32'h7FFF_FFFF);

    // reset in cycle 10 aborts the operation
    launch(DIV_OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(bus.busy), 32'h0);
    check("abort done", 32'(bus.done), 32'h0);
    check("abort result", bus.result, 32'h0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort no done", 32'(dn), 32'h0);
    run("div after abort", DIV_OP_DIV, 32'd100, 32'd7,
        32'd14, 33, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
